// File: rtl/dac_frame_player.sv
// dac_frame_player
// Ping-pong sample store feeding a serial DAC. The upstream stream fills the
// bank not selected by SEL. Each falling edge of i640 plays the word at ADR
// from the SEL bank, shifted MSB first on dac_din framed by dac_sync_n.
module dac_frame_player #(
    parameter int DW       = 12,
    parameter int DEPTH    = 81,
    parameter int AW       = 7,
    parameter int SCLK_DIV = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i640,
    input  logic [AW-1:0] ADR,
    input  logic          SEL,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_full,
    output logic          dac_sclk,
    output logic          dac_din,
    output logic          dac_sync_n,
    output logic          busy,
    output logic          err_overrun,
    output logic          err_underrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int BW = $clog2(DW);
    localparam int CW = $clog2(SCLK_DIV + 1);

    localparam logic [AW-1:0] FULL_PTR = AW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(SCLK_DIV - 1);

    // bank index is the first dimension, i.e. the MSB of the flat address
    logic [DW-1:0] mem [0:1][0:DEPTH-1];

    logic [AW-1:0] wr_ptr;
    logic          sel_d;
    logic          i640_d;
    logic [1:0]    state;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] div_cnt;

    logic          adr_ok;
    logic [AW-1:0] rd_idx;
    logic          fall;
    logic          swap;
    logic          wr_accept;

    logic          adr_ok_p0;
    logic [DW-1:0] rd_data_p1;
    logic [DW-1:0] sreg;

    assign fall      = i640_d & ~i640;
    assign swap      = (SEL != sel_d);
    assign wr_accept = wr_en && (wr_ptr != FULL_PTR);
    assign adr_ok    = (ADR < FULL_PTR);
    // out-of-range addresses read a legal word; FETCH replaces it with zero
    assign rd_idx    = adr_ok ? ADR : '0;

    // data is only meaningful inside a frame, so gate it with the frame strobe
    assign dac_din   = ~dac_sync_n & sreg[DW-1];

    // Sample RAM: write port into bank ~SEL, read port from bank SEL on a frame start
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (swap) begin
                if (wr_en) begin
                    mem[~SEL][0] <= wr_data;
                end
            end else if (wr_accept) begin
                mem[~SEL][wr_ptr] <= wr_data;
            end
        end
        if (state == S_IDLE && fall) begin
            rd_data_p1 <= mem[SEL][rd_idx];
        end
    end

    // Write pointer, full flag and underrun detection on bank swap
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            sel_d        <= 1'b0;
            wr_full      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            sel_d        <= SEL;
            err_underrun <= 1'b0;
            if (swap) begin
                err_underrun <= (wr_ptr != FULL_PTR);
                wr_ptr       <= wr_en ? AW'(1) : '0;
                wr_full      <= wr_en && (FULL_PTR == AW'(1));
            end else if (wr_accept) begin
                wr_ptr  <= wr_ptr + AW'(1);
                wr_full <= ((wr_ptr + AW'(1)) == FULL_PTR);
            end
        end
    end

    // Frame sequencer: fetch, serialise DW bits on sclk, then close the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            i640_d      <= 1'b1;
            busy        <= 1'b0;
            dac_sync_n  <= 1'b1;
            dac_sclk    <= 1'b0;
            err_overrun <= 1'b0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
        end else begin
            i640_d      <= i640;
            err_overrun <= fall & busy;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    dac_sync_n <= 1'b0;
                    dac_sclk   <= 1'b0;
                    bit_cnt    <= '0;
                    div_cnt    <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_cnt == LAST_DIV) begin
                        div_cnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                            // the last high half-period is closed out by DONE
                            if (bit_cnt == LAST_BIT) begin
                                state <= S_DONE;
                            end
                        end else begin
                            dac_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + BW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (div_cnt == LAST_DIV) begin
                        div_cnt    <= '0;
                        dac_sclk   <= 1'b0;
                        dac_sync_n <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shift datapath: capture address range, load read data, shift on sclk fall
    always_ff @(posedge clk) begin
        if (state == S_IDLE && fall) begin
            adr_ok_p0 <= adr_ok;
        end
        if (state == S_FETCH) begin
            sreg <= adr_ok_p0 ? rd_data_p1 : '0;
        end else if (state == S_SHIFT && div_cnt == LAST_DIV && dac_sclk) begin
            sreg <= sreg << 1;
        end
    end

endmodule

// File: tb/tb_dac_frame_player.sv
// tb_dac_frame_player
// Randomised bench for dac_frame_player with a bank-content reference model
// and a serial-frame monitor that reassembles the word seen by the DAC.
module tb_dac_frame_player;

    localparam int DW       = 12;
    localparam int DEPTH    = 81;
    localparam int AW       = 7;
    localparam int FRAME    = DW * 2 * 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i640;
    logic [AW-1:0] ADR;
    logic          SEL;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          dac_sclk;
    logic          dac_din;
    logic          dac_sync_n;
    logic          busy;
    logic          err_overrun;
    logic          err_underrun;

    dac_frame_player dut (
        .clk          (clk),
        .reset        (reset),
        .i640         (i640),
        .ADR          (ADR),
        .SEL          (SEL),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .dac_sclk     (dac_sclk),
        .dac_din      (dac_din),
        .dac_sync_n   (dac_sync_n),
        .busy         (busy),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: bank contents, words in the write bank, play bank
    logic [DW-1:0] mdl_mem [0:1][0:DEPTH-1];
    int            mdl_cnt = 0;
    logic          mdl_sel = 1'b0;

    // serial monitor, cumulative counters sampled on the falling clock edge
    int            sync_low = 0;
    int            rises    = 0;
    int            ovr_cnt  = 0;
    logic          sclk_prev = 1'b0;
    logic [DW-1:0] cap = '0;

    always @(negedge clk) begin
        if (dac_sync_n === 1'b0) sync_low = sync_low + 1;
        if (dac_sclk === 1'b1 && sclk_prev === 1'b0 && dac_sync_n === 1'b0) begin
            rises = rises + 1;
            cap   = {cap[DW-2:0], dac_din};
        end
        sclk_prev = dac_sclk;
        if (err_overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (mdl_cnt < DEPTH) begin
            mdl_mem[~mdl_sel][mdl_cnt] = d;
            mdl_cnt++;
        end
        check("wr_full", {31'd0, wr_full}, {31'd0, mdl_cnt == DEPTH});
    endtask

    task automatic swap_banks(input logic with_wr, input logic [DW-1:0] d);
        logic exp_und;
        exp_und = (mdl_cnt != DEPTH);
        SEL     = ~SEL;
        wr_en   = with_wr;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        mdl_sel = SEL;
        mdl_cnt = 0;
        if (with_wr) begin
            mdl_mem[~mdl_sel][0] = d;
            mdl_cnt = 1;
        end
        check("underrun_pulse", {31'd0, err_underrun}, {31'd0, exp_und});
        tick();
        check("underrun_width", {31'd0, err_underrun}, 32'd0);
        check("wr_full_after_swap", {31'd0, wr_full}, 32'd0);
    endtask

    // play one frame; ovr_at>0 injects a second fall that many cycles in
    task automatic play(input logic [AW-1:0] a, input int ovr_at, input string tag);
        int s_low, s_r, s_o, n;
        logic [DW-1:0] exp;
        exp   = (a < DEPTH) ? mdl_mem[mdl_sel][a] : '0;
        s_low = sync_low;
        s_r   = rises;
        s_o   = ovr_cnt;
        ADR   = a;
        i640  = 1'b0;
        tick();
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        check({tag, "_sync_pre"}, {31'd0, dac_sync_n}, 32'd1);
        i640 = 1'b1;
        tick();
        check({tag, "_sync_fall"}, {31'd0, dac_sync_n}, 32'd0);
        n = 0;
        while (busy && n < 200) begin
            i640 = (ovr_at != 0 && n == ovr_at) ? 1'b0 : 1'b1;
            tick();
            n++;
        end
        i640 = 1'b1;
        check({tag, "_busy_len"}, n, FRAME);
        check({tag, "_sync_end"}, {31'd0, dac_sync_n}, 32'd1);
        repeat (8) tick();
        check({tag, "_word"}, {20'd0, cap}, {20'd0, exp});
        check({tag, "_rises"}, rises - s_r, DW);
        check({tag, "_sync_low"}, sync_low - s_low, FRAME);
        check({tag, "_overrun"}, ovr_cnt - s_o, (ovr_at != 0) ? 1 : 0);
    endtask

    initial begin
        int s_r, n;
        logic [DW-1:0] d;
        reset   = 1'b1;
        i640    = 1'b1;
        ADR     = '0;
        SEL     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) tick();
        check("rst_sync_n", {31'd0, dac_sync_n}, 32'd1);
        check("rst_sclk", {31'd0, dac_sclk}, 32'd0);
        check("rst_din", {31'd0, dac_din}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, wr_full}, 32'd0);
        check("rst_errs", {30'd0, err_overrun, err_underrun}, 32'd0);
        reset = 1'b0;
        tick();

        // fill bank 1 with a known ramp and play address 5
        for (int i = 0; i < DEPTH; i++) wr(DW'(12'hA00 + i));
        swap_banks(1'b0, '0);
        play(7'd5, 0, "ramp");

        // overfill bank 0: the extra word is dropped silently
        for (int i = 0; i < DEPTH + 1; i++) wr(DW'($urandom_range(0, 4095)));
        swap_banks(1'b0, '0);
        play(7'd80, 0, "last_word");

        // early swap with a simultaneous write
        for (int i = 0; i < 40; i++) wr(DW'($urandom_range(0, 4095)));
        d = DW'($urandom_range(0, 4095));
        swap_banks(1'b1, d);
        swap_banks(1'b0, '0);
        play(7'd0, 0, "swap_word");

        // second frame strobe during a transfer
        play(7'($urandom_range(0, DEPTH - 1)), 18, "overrun");

        // address beyond the bank plays zeros
        play(7'd100, 0, "oob");

        // random bank fills and random addresses
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                wr(DW'($urandom_range(0, 4095)));
            end
            swap_banks(1'b0, '0);
            play(7'($urandom_range(0, 99)), 0, "rand_a");
            play(7'($urandom_range(0, DEPTH - 1)), 0, "rand_b");
        end

        // reset in the middle of a frame
        s_r  = rises;
        ADR  = 7'd3;
        i640 = 1'b0;
        tick();
        i640 = 1'b1;
        n = 0;
        while ((rises - s_r) < 6 && n < 100) begin
            tick();
            n++;
        end
        check("abort_bits", rises - s_r, 6);
        reset = 1'b1;
        SEL   = 1'b0;
        tick();
        check("abort_sync_n", {31'd0, dac_sync_n}, 32'd1);
        check("abort_sclk", {31'd0, dac_sclk}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        reset   = 1'b0;
        mdl_sel = 1'b0;
        mdl_cnt = 0;
        tick();
        play(7'($urandom_range(0, DEPTH - 1)), 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
